// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by fetch_queue and fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    END   = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

  // True when a byte address maps to a word inside instruction memory.
  function automatic logic in_range(
    input logic [31:0] addr,
    input int unsigned dep
  );
    return (addr >> 2) < dep;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular FIFO of {pc, instr} entries.
// Pointers wrap naturally; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A flush overrides both sides of the handshake.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, FSM, redirect, prefetch queue.
// Define FETCH_PERF_EN to build the saturating perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_DEP     = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic         fetching;
  logic         pop;
  logic         enq;
  logic         q_empty;
  logic         q_full;
  logic [AW:0]  q_count;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign target = {redirect_pc[31:2], 2'b00};
  assign pc_inc = pc + INSTR_BYTES;

  assign pop = ~q_empty & out_ready;
  assign enq = fetching
             & ~redirect_valid
             & (~q_full | pop);

  assign wr_entry = '{pc: pc, instr: imem_data};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

  // Program counter: redirect wins, otherwise advance per enqueue
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= target;
    else if (enq)
      pc <= pc_inc;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state; a redirect is honoured from any state
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (!in_range(target, MEM_DEP))
        state_nxt = END;
      else if (fetch_en)
        state_nxt = FETCH;
      else
        state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en)
            state_nxt = FETCH;
        end
        FETCH: begin
          if (enq && !in_range(pc_inc, MEM_DEP))
            state_nxt = END;
          else if (!fetch_en)
            state_nxt = IDLE;
        end
        END: state_nxt = END;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: only FETCH may write the queue
  always_comb begin
    fetching = 1'b0;
    unique case (state)
      FETCH:   fetching = 1'b1;
      default: fetching = 1'b0;
    endcase
  end

  assign imem_addr = pc;
  assign out_valid = (q_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic        stall;

  assign stall = fetching & q_full & ~pop;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (enq && fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based model.
// Perf expectations follow whether FETCH_PERF_EN is defined.
module tb_fetch_unit;

  localparam int          QD  = 4;
  localparam int          MEM = 32;
  localparam logic [31:0] RPC = 32'h0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  logic [31:0] mem [64];

  int passed = 0;
  int total  = 0;

  logic [63:0] mq [$];
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;

  fetch_unit #(
    .QUEUE_DEPTH (QD),
    .RESET_PC    (RPC),
    .MEM_DEP     (MEM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256)
      return mem[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_data = mem_word(imem_addr);

  function automatic logic [160:0] got_vec();
    return {out_valid, out_pc, out_instr, imem_addr,
            perf_fetch_cnt, perf_stall_cnt};
  endfunction

  function automatic logic [160:0] exp_vec();
    logic [63:0] h;
    h = (mq.size() != 0) ? mq[0] : 64'h0;
    return {mq.size() != 0, h, m_pc,
            PERF ? m_fcnt : 32'h0,
            PERF ? m_scnt : 32'h0};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc   = RPC;
    m_mode = M_IDLE;
    m_fcnt = 0;
    m_scnt = 0;
  endtask

  task automatic model_update();
    bit pp;
    bit en;
    pp = (mq.size() != 0) && out_ready;
    if (m_mode == M_RUN && mq.size() == QD && !pp)
      m_scnt++;
    if (redirect_valid) begin
      mq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if ((m_pc >> 2) >= MEM)
        m_mode = M_STOP;
      else
        m_mode = fetch_en ? M_RUN : M_IDLE;
    end else begin
      en = (m_mode == M_RUN) && (mq.size() < QD || pp);
      if (pp)
        void'(mq.pop_front());
      if (en) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_fcnt++;
        m_pc = m_pc + 32'd4;
      end
      if (m_mode == M_IDLE && fetch_en)
        m_mode = M_RUN;
      else if (m_mode == M_RUN) begin
        if (en && (m_pc >> 2) >= MEM)
          m_mode = M_STOP;
        else if (!fetch_en)
          m_mode = M_IDLE;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic [160:0] want;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    want = {1'b0, 32'h0, 32'h0, RPC, 32'h0, 32'h0};
    total++;
    if (got_vec() !== want)
      $display("FAIL reset got %h exp %h", got_vec(), want);
    else
      passed++;
    #1;
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_seq_fetch();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      total++;
      if (got_vec() !== exp_vec())
        $display("FAIL seq c%0d got %h exp %h",
                 i, got_vec(), exp_vec());
      else
        passed++;
      if (i >= 2) begin
        total++;
        if (out_valid !== 1'b1 ||
            out_pc !== 32'(4 * (i - 2)) ||
            out_instr !== mem[i - 2])
          $display("FAIL seq_head c%0d got v%b %h/%h exp pc %h",
                   i, out_valid, out_pc, out_instr, 4 * (i - 2));
        else
          passed++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ws;
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      total++;
      if (got_vec() !== exp_vec())
        $display("FAIL bp_fill c%0d got %h exp %h",
                 i, got_vec(), exp_vec());
      else
        passed++;
      step();
    end
    #2;
    ws = PERF ? 32'd5 : 32'd0;
    total++;
    if (imem_addr !== 32'd16 || out_pc !== 32'd0 ||
        perf_stall_cnt !== ws)
      $display("FAIL bp_hold got addr %h pc %h stall %0d exp 10/0/%0d",
               imem_addr, out_pc, perf_stall_cnt, ws);
    else
      passed++;
    out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j > 0)
        #2;
      total++;
      if (got_vec() !== exp_vec() || out_pc !== 32'(4 * j))
        $display("FAIL bp_drain c%0d got %h exp %h",
                 j, got_vec(), exp_vec());
      else
        passed++;
      step();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (3) begin
      #2;
      total++;
      if (got_vec() !== exp_vec())
        $display("FAIL rd_pre got %h exp %h", got_vec(), exp_vec());
      else
        passed++;
      step();
    end
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40)
      $display("FAIL rd_flush got v%b addr %h exp v0 addr 40",
               out_valid, imem_addr);
    else
      passed++;
    step();
    #2;
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 ||
        out_instr !== mem[16])
      $display("FAIL rd_head got v%b %h/%h exp 40/%h",
               out_valid, out_pc, out_instr, mem[16]);
    else
      passed++;
    total++;
    if (got_vec() !== exp_vec())
      $display("FAIL rd_model got %h exp %h", got_vec(), exp_vec());
    else
      passed++;
    step();
  endtask

  task automatic test_end_of_mem();
    logic [31:0] last_pc;
    last_pc        = 32'hFFFF_FFFF;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h60;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (out_valid === 1'b1)
        last_pc = out_pc;
      total++;
      if (got_vec() !== exp_vec())
        $display("FAIL end c%0d got %h exp %h",
                 i, got_vec(), exp_vec());
      else
        passed++;
      fetch_en = (i % 7) != 3;
      step();
    end
    #2;
    total++;
    if (last_pc !== 32'h7C || imem_addr !== 32'h80 ||
        out_valid !== 1'b0)
      $display("FAIL end_stop got last %h addr %h v%b exp 7c/80/0",
               last_pc, imem_addr, out_valid);
    else
      passed++;
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    step();
    #2;
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8)
      $display("FAIL end_resume got v%b pc %h exp v1 pc 8",
               out_valid, out_pc);
    else
      passed++;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    repeat (4) step();
    #2;
    total++;
    if (got_vec() !== exp_vec() || mq.size() != 3)
      $display("FAIL mid_pre got %h exp %h", got_vec(), exp_vec());
    else
      passed++;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== RPC ||
        perf_fetch_cnt !== 32'h0)
      $display("FAIL mid_rst got v%b addr %h fc %0d exp v0 addr %h fc 0",
               out_valid, imem_addr, perf_fetch_cnt, RPC);
    else
      passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    #2;
    total++;
    if (got_vec() !== exp_vec())
      $display("FAIL mid_post got %h exp %h", got_vec(), exp_vec());
    else
      passed++;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fetch_en       = $urandom_range(0, 9) != 0;
      out_ready      = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc    = 32'($urandom_range(0, 47) * 4
                         + $urandom_range(0, 3));
      #2;
      total++;
      if (got_vec() !== exp_vec())
        $display("FAIL rand c%0d got %h exp %h",
                 i, got_vec(), exp_vec());
      else
        passed++;
      step();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      mem[k] = $urandom;
    m_reset();
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_redirect();
    test_end_of_mem();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
